// File: rtl/cc_fill_pkg.sv
// Shared types and helpers for the cache-line fill unit.
package cc_fill_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_LINE_BYTES = 64;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_IDX_W      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } fill_state_t;

  // Ceiling log2, used for every derived width (beat count, offsets).
  function automatic int clog2_beats(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cc_fill_line_buf.sv
// Line assembly buffer: BEATS beat-wide slots, one slot written per cycle,
// whole line presented flat.
module cc_fill_line_buf #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int WOFF_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [WOFF_W-1:0]       widx,
  input  logic [DATA_W-1:0]       wdata,
  output logic [BEATS*DATA_W-1:0] line
);

  logic [DATA_W-1:0] slot_q [BEATS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS; i++) slot_q[i] <= '0;
    end else if (we) begin
      slot_q[widx] <= wdata;
    end
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < BEATS; i++) line[i*DATA_W +: DATA_W] = slot_q[i];
  end

endmodule

// File: rtl/cc_line_fill_unit.sv
// Cache-line fill unit: pops a miss address, gathers a wrapping AXI R burst
// into a line and writes tag+line once. Optional early critical-word forward
// is built when CC_FILL_CWF_EN is defined.
module cc_line_fill_unit
  import cc_fill_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int IDX_W      = DEF_IDX_W,
  localparam int BEATS     = LINE_BYTES * 8 / DATA_W,
  localparam int OFF_W     = clog2_beats(LINE_BYTES),
  localparam int WOFF_W    = clog2_beats(BEATS),
  localparam int BOFF_W    = clog2_beats(DATA_W / 8),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  input  logic                    mem_rlast_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_rready_o,
  input  logic                    miss_addr_fifo_empty_i,
  input  logic [ADDR_W-1:0]       miss_addr_fifo_rdata_i,
  output logic                    miss_addr_fifo_rden_o,
  output logic                    wren_o,
  output logic [IDX_W-1:0]        waddr_o,
  output logic [TAG_W:0]          wdata_tag_o,
  output logic [LINE_BYTES*8-1:0] wdata_data_o,
  output logic [1:0]              dbg_state_o,
  output logic                    fill_err_o
`ifdef CC_FILL_CWF_EN
  ,
  output logic                    cwf_valid_o,
  output logic [DATA_W-1:0]       cwf_data_o
`endif
);

  fill_state_t       state_q;
  logic [WOFF_W-1:0] cnt_q;
  logic [WOFF_W-1:0] start_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic              err_q;
  logic              beat_hs;
  logic              cnt_last;
  logic              unused_addr_bits;

  // A beat transfers on any cycle where mem_rvalid_i and mem_rready_o are both
  // high; rready depends only on state, so the source may hold rvalid freely.
  assign mem_rready_o          = (state_q == FILL) || (state_q == DRAIN);
  assign miss_addr_fifo_rden_o = (state_q == IDLE) && !miss_addr_fifo_empty_i;
  assign beat_hs               = (state_q == FILL) && mem_rvalid_i;
  assign cnt_last              = (cnt_q == WOFF_W'(BEATS - 1));

  assign wren_o      = (state_q == WRITE);
  assign waddr_o     = idx_q;
  assign wdata_tag_o = {wren_o, tag_q};
  assign fill_err_o  = err_q;
  assign dbg_state_o = state_q;

  assign unused_addr_bits = ^miss_addr_fifo_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!miss_addr_fifo_empty_i) begin
            idx_q   <= miss_addr_fifo_rdata_i[OFF_W+IDX_W-1:OFF_W];
            tag_q   <= miss_addr_fifo_rdata_i[ADDR_W-1:OFF_W+IDX_W];
            start_q <= miss_addr_fifo_rdata_i[OFF_W-1:BOFF_W];
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (mem_rlast_i) begin
              if (cnt_last) begin
                state_q <= WRITE;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end else if (cnt_last) begin
              // Burst overran the line: flush the tail without writing.
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end
          end
        end
        WRITE: state_q <= IDLE;
        DRAIN: begin
          if (mem_rvalid_i && mem_rlast_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cc_fill_line_buf #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .WOFF_W (WOFF_W)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (beat_hs),
    .widx  (start_q + cnt_q),
    .wdata (mem_rdata_i),
    .line  (wdata_data_o)
  );

`ifdef CC_FILL_CWF_EN
  logic              cwf_valid_q;
  logic [DATA_W-1:0] cwf_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwf_valid_q <= 1'b0;
      cwf_data_q  <= '0;
    end else begin
      cwf_valid_q <= beat_hs && (cnt_q == '0);
      if (beat_hs && (cnt_q == '0)) cwf_data_q <= mem_rdata_i;
    end
  end

  assign cwf_valid_o = cwf_valid_q;
  assign cwf_data_o  = cwf_data_q;
`endif

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// Bench for cc_line_fill_unit: directed bursts with a scoreboard of expected
// SRAM writes, error pulses and (with CC_FILL_CWF_EN) critical-word forwards.
module tb_cc_line_fill_unit;

  localparam int DATA_W     = 64;
  localparam int LINE_BYTES = 64;
  localparam int ADDR_W     = 32;
  localparam int IDX_W      = 9;
  localparam int BEATS      = 8;
  localparam int TAG_W      = 17;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int EXP_W      = IDX_W + TAG_W + 1 + LINE_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic                mem_rlast = 1'b0;
  logic                mem_rvalid = 1'b0;
  logic                mem_rready_o;
  logic                fifo_empty = 1'b1;
  logic [ADDR_W-1:0]   fifo_rdata = '0;
  logic                fifo_rden_o;
  logic                wren_o;
  logic [IDX_W-1:0]    waddr_o;
  logic [TAG_W:0]      wdata_tag_o;
  logic [LINE_W-1:0]   wdata_data_o;
  logic [1:0]          dbg_state_o;
  logic                fill_err_o;
`ifdef CC_FILL_CWF_EN
  logic                cwf_valid_o;
  logic [DATA_W-1:0]   cwf_data_o;
`endif

  cc_line_fill_unit dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mem_rdata_i            (mem_rdata),
    .mem_rlast_i            (mem_rlast),
    .mem_rvalid_i           (mem_rvalid),
    .mem_rready_o           (mem_rready_o),
    .miss_addr_fifo_empty_i (fifo_empty),
    .miss_addr_fifo_rdata_i (fifo_rdata),
    .miss_addr_fifo_rden_o  (fifo_rden_o),
    .wren_o                 (wren_o),
    .waddr_o                (waddr_o),
    .wdata_tag_o            (wdata_tag_o),
    .wdata_data_o           (wdata_data_o),
    .dbg_state_o            (dbg_state_o),
    .fill_err_o             (fill_err_o)
`ifdef CC_FILL_CWF_EN
    ,
    .cwf_valid_o            (cwf_valid_o),
    .cwf_data_o             (cwf_data_o)
`endif
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0]  exp_q[$];
  int                err_pending = 0;
  logic [ADDR_W-1:0] fifo_q[$];
  int                pop_cyc = 0;
  int                wren_cyc = 0;
  int                err_cyc = 0;
`ifdef CC_FILL_CWF_EN
  logic [DATA_W-1:0] cwf_q[$];
`endif

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input int start,
                                                input logic [DATA_W-1:0] b[10]);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < BEATS; i++) l[((start + i) % BEATS)*DATA_W +: DATA_W] = b[i];
    return l;
  endfunction

  task automatic push_exp(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input logic [LINE_W-1:0] line);
    exp_q.push_back({idx, 1'b1, tag, line});
  endtask

  // ---------------- miss-address FIFO model ----------------
  always begin
    @(negedge clk);
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    #1;
    if (fifo_rden_o && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cyc = cyc;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (wren_o) begin
        wren_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wren: got waddr %0h want no write", waddr_o);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          check("waddr", waddr_o, e[EXP_W-1 -: IDX_W]);
          check("wdata_tag", wdata_tag_o, e[LINE_W+TAG_W:LINE_W]);
          check("wdata_line", wdata_data_o, e[LINE_W-1:0]);
        end
      end
      if (fill_err_o) begin
        err_cyc = cyc;
        checks++;
        if (err_pending > 0) err_pending--;
        else begin
          errors++;
          $display("FAIL unexpected_fill_err: got 1 want 0");
        end
      end
`ifdef CC_FILL_CWF_EN
      if (cwf_valid_o) begin
        if (cwf_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cwf: got %0h want none", cwf_data_o);
        end else begin
          check("cwf_data", cwf_data_o, cwf_q.pop_front());
        end
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    mem_rlast  = last;
    n = 0;
    while (!mem_rready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got rready 0 want 1 within 200 cycles");
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
  endtask

  // last_at is 1-based; 0 means rlast never set
  task automatic send_burst(input logic [DATA_W-1:0] b[10], input int n,
                            input int last_at, input int gap);
`ifdef CC_FILL_CWF_EN
    cwf_q.push_back(b[0]);
`endif
    for (int i = 0; i < n; i++) send_beat(b[i], (i + 1) == last_at, (i == 0) ? 0 : gap);
    bus_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"}, wren_o, 0);
    check({tag, "_err"}, fill_err_o, 0);
    check({tag, "_rready"}, mem_rready_o, 0);
    check({tag, "_rden"}, fifo_rden_o, 0);
    check({tag, "_waddr"}, waddr_o, 0);
    check({tag, "_tag"}, wdata_tag_o, 0);
    check({tag, "_line"}, wdata_data_o, 0);
`ifdef CC_FILL_CWF_EN
    check({tag, "_cwf_valid"}, cwf_valid_o, 0);
    check({tag, "_cwf_data"}, cwf_data_o, 0);
`endif
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: got no finish want finish before 300000");
    summary();
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  logic [DATA_W-1:0] bv[10];
  logic [DATA_W-1:0] cv[10];
  int n;

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Aligned fill: index 0x08D, tag 0x00002, word 0, beats 0x11..0x88
    for (int i = 0; i < 10; i++) bv[i] = DATA_W'((i + 1) * 'h11);
    push_exp(9'h08D, 17'h00002, mk_line(0, bv));
    fifo_q.push_back(32'h0001_2340);
    send_burst(bv, 8, 8, 0);
    repeat (3) @(negedge clk);
    check("aligned_wren_latency", wren_cyc - pop_cyc, 9);
    check("aligned_word0", wdata_data_o[63:0], 64'h11);

    // Wrapped fill: offset 0x28 -> word 5, index 0x180, tag 0x1579B
    for (int i = 0; i < 10; i++) bv[i] = 64'hA000_0000_0000_0000 | DATA_W'(i + 1);
    push_exp(9'h180, 17'h1579B, mk_line(5, bv));
    fifo_q.push_back(32'hABCD_E028);
    send_burst(bv, 8, 8, 0);
    repeat (3) @(negedge clk);

    // Stalls: FIFO empty with rvalid held high, then rvalid toggling
    for (int i = 0; i < 10; i++) bv[i] = 64'h5500_0000_0000_0000 | DATA_W'(i * 3 + 7);
`ifdef CC_FILL_CWF_EN
    cwf_q.push_back(bv[0]);
`endif
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = bv[0];
    mem_rlast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("rready_while_fifo_empty", mem_rready_o, 0);
      @(negedge clk);
    end
    push_exp(9'h1FF, 17'h00000, mk_line(7, bv));
    fifo_q.push_back(32'h0000_7FF8);
    n = 0;
    while (!mem_rready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stall_first_beat_accepted", n < 200, 1);
    for (int i = 1; i < BEATS; i++) send_beat(bv[i], i == BEATS - 1, 1);
    bus_idle();
    repeat (3) @(negedge clk);

    // Early rlast on beat 3, next entry queued behind it
    for (int i = 0; i < 10; i++) bv[i] = 64'hEE00 | DATA_W'(i);
    for (int i = 0; i < 10; i++) cv[i] = 64'hC0DE_0000_0000_0000 | DATA_W'(i + 16);
    err_pending++;
    push_exp(9'h159, 17'h02468, mk_line(7, cv));
    fifo_q.push_back(32'h0000_0040);
    fifo_q.push_back(32'h1234_5678);
    send_burst(bv, 3, 3, 0);
    send_burst(cv, 8, 8, 0);
    repeat (3) @(negedge clk);
    check("pop_in_err_cycle", pop_cyc, err_cyc);

    // Missing rlast: 10-beat burst, rlast on beat 10, then a good fill
    for (int i = 0; i < 10; i++) bv[i] = 64'hBAD0 | DATA_W'(i);
    for (int i = 0; i < 10; i++) cv[i] = 64'h0123_4567_0000_0000 | DATA_W'(i * 5);
    err_pending++;
    push_exp(9'h003, 17'h00000, mk_line(1, cv));
    fifo_q.push_back(32'h0000_0080);
    fifo_q.push_back(32'h0000_00C8);
    send_burst(bv, 10, 10, 0);
    send_burst(cv, 8, 8, 0);
    repeat (3) @(negedge clk);

    // Reset after beat 4, then a fresh fill
    for (int i = 0; i < 10; i++) bv[i] = 64'h7700 | DATA_W'(i);
    fifo_q.push_back(32'h0000_0100);
    send_burst(bv, 4, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cv[i] = 64'hF00D_0000_0000_0000 | DATA_W'(i + 1);
    push_exp(9'h004, 17'h00000, mk_line(2, cv));
    fifo_q.push_back(32'h0000_0110);
    send_burst(cv, 8, 8, 0);
    repeat (5) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    check("err_pending_drained", err_pending, 0);
`ifdef CC_FILL_CWF_EN
    check("cwf_q_drained", cwf_q.size(), 0);
`endif
    summary();
    $finish;
  end

endmodule
